pulse_conditioner: RTL and testbench
====================================

# pulse_conditioner

Input-conditioning stage that feeds `in_bit` of the 4-bit accumulator. It synchronises an asynchronous raw input into `clk`, then debounces it with a stable-count state machine. For each accepted rising edge it emits exactly one single-cycle pulse, so the downstream accumulator increments once per clean event.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples needed to accept a level change. Legal range 1..255; the internal counter is 8 bits.

- `clk`  in  1  single clock; everything is rising-edge triggered.
- `rst`  in  1  reset, asynchronous, active-high. Clears all state immediately.
- `raw_in`  in  1  raw asynchronous input (switch or sensor); may glitch.
- `enable`  in  1  pulse gate. When 0, `in_bit` is forced low and debouncing continues.
- `in_bit`  out  1  one-cycle pulse per accepted rising edge; connects to accumulator `in_bit`.
- `level_out`  out  1  registered debounced level.
- `busy`  out  1  high while the FSM is in PEND_HI or PEND_LO.

## Operation
- **Synchroniser**
  - Two flops, `s1 <= raw_in`, `s2 <= s1`, both reset to 0.
  - The FSM observes only `s2`.
- **FSM states:** STABLE_LO (reset state), PEND_HI, STABLE_HI, PEND_LO. Counter `cnt` is 8 bits and resets to 0.
- **STABLE_LO**
  - `s2`=1 and `DEBOUNCE_CYCLES`==1: go to STABLE_HI and accept.
  - `s2`=1 otherwise: go to PEND_HI with `cnt`<=1.
  - `s2`=0: stay.
- **PEND_HI**
  - `s2`=0: back to STABLE_LO with `cnt`<=0. The glitch is rejected and no output changes.
  - `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`-1: go to STABLE_HI and accept.
  - Otherwise: `cnt`<=`cnt`+1.
- **Accept rising:** `level_out`<=1 and `cnt`<=0. `in_bit`<=`enable` (as sampled that cycle) for exactly one cycle.
- **STABLE_HI and PEND_LO:** mirror of the above with `s2` inverted. Acceptance sets `level_out`<=0 and emits no pulse, unless the macro is defined (see Configuration).
- **Pulse rules**
  - `in_bit` is registered, never combinational.
  - `in_bit` is never high on two consecutive cycles.
  - A pulse suppressed by `enable`=0 is dropped, not queued.
- `busy` = (state==PEND_HI) or (state==PEND_LO), registered with the state.

## Timing
- **Reset values:** `in_bit`=0, `level_out`=0, `busy`=0, state=STABLE_LO, `cnt`=0, `s1`=`s2`=0.
- **Rising-edge latency:** if `raw_in` rises and stays high between edges, with edge 1 being the first edge after the rise:
  - `in_bit` and `level_out` go high after edge 2+`DEBOUNCE_CYCLES`.
  - `in_bit` goes low after edge 3+`DEBOUNCE_CYCLES`.
  - With the default of 4: high after edge 6.
- **Falling-edge latency:** identical, 2+`DEBOUNCE_CYCLES` edges to `level_out`=0.
- **Glitch rejection:** any high excursion of `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no pulse and leaves `level_out` unchanged.
- **Minimum event spacing:** pulses are at least 2×`DEBOUNCE_CYCLES` cycles apart, one full high plus low acceptance.
- **Reset mid-pending:** the pending count is abandoned and all outputs clear immediately.
  - After release, a `raw_in` that is still high is treated as a new rising edge.
  - It takes the full 2+`DEBOUNCE_CYCLES` latency and produces one pulse.
- **`enable` changes:** take effect on the acceptance cycle only. `enable` has no effect on state or `level_out`.

## Configuration
- `PULSE_COND_BOTH_EDGES_EN` defined:
  - Falling-edge acceptance also emits a one-cycle `in_bit` pulse, gated by `enable`.
  - The accumulator then counts every debounced transition.
- Macro undefined: only rising acceptance pulses. Falling acceptance updates `level_out` only.

## Test plan
1. **Reset release.** Assert `rst`, release, `raw_in`=0 for 20 cycles. Expect `in_bit`=`level_out`=`busy`=0 throughout, and asynchronous clear when `rst` is asserted mid-cycle.
2. **Clean rise.** `DEBOUNCE_CYCLES`=4, `raw_in` 0→1 held. Expect `in_bit` high exactly one cycle after edge 6, `level_out`=1 from edge 6, and `busy` high for edges 3–5.
3. **Glitch.** `raw_in` high for 3 cycles then low. Expect no `in_bit` pulse, `level_out`=0, and `busy` drops back to 0.
4. **Bounce then settle.** Pattern 1,0,1,1,0,1,1,1,1 held high. Expect exactly one `in_bit` pulse and an accumulator downstream reading 1.
5. **Enable and reset.**
   - `enable`=0 during acceptance: expect no pulse and `level_out`=1.
   - Reset while in PEND_HI with `raw_in` held high: after release, expect one pulse at edge 2+`DEBOUNCE_CYCLES`.
6. **Both edges.** With `PULSE_COND_BOTH_EDGES_EN`, a full 0→1→0 cycle yields two pulses. Without it, the same cycle yields one pulse.

Source files
------------

// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronises and debounces a raw asynchronous input and
// emits one registered single-cycle in_bit pulse per accepted rising edge.
// Optional build macro PULSE_COND_BOTH_EDGES_EN: falling acceptances also
// emit a pulse, so every debounced transition is counted downstream.
module pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic enable,
  output logic in_bit,
  output logic level_out,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  // Count value on which the last required matching sample arrives.
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

`ifdef PULSE_COND_BOTH_EDGES_EN
  localparam logic FALL_PULSE = 1'b1;
`else
  localparam logic FALL_PULSE = 1'b0;
`endif

  logic       s1;
  logic       s2;
  state_t     state;
  logic [7:0] cnt;

  // Two-flop synchroniser; only s2 is ever seen by the state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Debounce FSM with registered level, pulse and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STABLE_LO;
      cnt       <= 8'd0;
      level_out <= 1'b0;
      in_bit    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Pulse lasts one cycle; busy is recomputed from the next state.
      in_bit <= 1'b0;
      busy   <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s2) begin
            if (SINGLE_SAMPLE) begin
              state     <= STABLE_HI;
              cnt       <= 8'd0;
              level_out <= 1'b1;
              in_bit    <= enable;
            end else begin
              state <= PEND_HI;
              cnt   <= 8'd1;
              busy  <= 1'b1;
            end
          end
        end
        PEND_HI: begin
          if (!s2) begin
            // Glitch shorter than the debounce window: discard it.
            state <= STABLE_LO;
            cnt   <= 8'd0;
          end else if (cnt == LAST_CNT) begin
            state     <= STABLE_HI;
            cnt       <= 8'd0;
            level_out <= 1'b1;
            in_bit    <= enable;
          end else begin
            cnt  <= cnt + 8'd1;
            busy <= 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            if (SINGLE_SAMPLE) begin
              state     <= STABLE_LO;
              cnt       <= 8'd0;
              level_out <= 1'b0;
              in_bit    <= enable & FALL_PULSE;
            end else begin
              state <= PEND_LO;
              cnt   <= 8'd1;
              busy  <= 1'b1;
            end
          end
        end
        PEND_LO: begin
          if (s2) begin
            state <= STABLE_HI;
            cnt   <= 8'd0;
          end else if (cnt == LAST_CNT) begin
            state     <= STABLE_LO;
            cnt       <= 8'd0;
            level_out <= 1'b0;
            in_bit    <= enable & FALL_PULSE;
          end else begin
            cnt  <= cnt + 8'd1;
            busy <= 1'b1;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Testbench for pulse_conditioner: two instances (DEBOUNCE_CYCLES 4 and 1)
// share the same stimulus and are compared against a sample-history model.
module tb_pulse_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_in = 1'b0;
  logic enable = 1'b1;
  logic ib0, lv0, bz0, ib1, lv1, bz1;

  int checks = 0;
  int errors = 0;

`ifdef PULSE_COND_BOTH_EDGES_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  pulse_conditioner #(.DEBOUNCE_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .in_bit(ib0), .level_out(lv0), .busy(bz0)
  );

  pulse_conditioner #(.DEBOUNCE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .in_bit(ib1), .level_out(lv1), .busy(bz1)
  );

  always #5 clk = ~clk;

  // Behavioural model: a level change is accepted once the last D
  // synchronised samples all disagree with the current debounced level.
  int   dval [2] = '{4, 1};
  logic m_s1 [2];
  logic m_s2 [2];
  logic [7:0] m_hist [2];
  logic m_level [2];
  logic m_busy [2];
  logic m_pulse [2];
  int   pulses0 = 0;

  typedef struct {
    logic raw;
    logic en;
    logic exp_in_bit;
    logic exp_level;
    logic exp_busy;
  } vec_t;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_hist[k] = '0;
      m_level[k] = 0; m_busy[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_clock(input logic raw, input logic en);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] mask;
      logic accept;
      logic sample;
      sample = m_s2[k];
      m_hist[k] = {m_hist[k][6:0], sample};
      mask = 8'((1 << dval[k]) - 1);
      if (m_level[k]) accept = ((m_hist[k] & mask) == 8'd0);
      else            accept = ((m_hist[k] & mask) == mask);
      m_pulse[k] = accept && en && (!m_level[k] || BOTH);
      m_busy[k]  = (sample != m_level[k]) && !accept;
      if (accept) m_level[k] = ~m_level[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = raw;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("d4_in_bit", ib0, m_pulse[0]);
    check("d4_level", lv0, m_level[0]);
    check("d4_busy", bz0, m_busy[0]);
    check("d1_in_bit", ib1, m_pulse[1]);
    check("d1_level", lv1, m_level[1]);
    check("d1_busy", bz1, m_busy[1]);
  endtask

  // One clock transaction: drive at negedge, model at posedge, check 1 later.
  task automatic step(input logic raw, input logic en, input logic r);
    @(negedge clk);
    raw_in = raw;
    enable = en;
    rst    = r;
    if (r) model_reset();
    @(posedge clk);
    if (!r) model_clock(raw, en);
    #1;
    compare_all();
    if (ib0) pulses0++;
    $display("t=%0t rst=%b raw=%b en=%b | d4 in_bit=%b level=%b busy=%b | d1 in_bit=%b level=%b busy=%b",
             $time, r, raw, en, ib0, lv0, bz0, ib1, lv1, bz1);
  endtask

  vec_t rise_tbl [8];
  int   pulse_edge;
  logic [3:0] acc;
  logic raw_r;
  int   bounce [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    // Clean rise with D=4: busy after edges 3..5, pulse and level after 6.
    rise_tbl[0] = '{1, 1, 0, 0, 0};
    rise_tbl[1] = '{1, 1, 0, 0, 0};
    rise_tbl[2] = '{1, 1, 0, 0, 1};
    rise_tbl[3] = '{1, 1, 0, 0, 1};
    rise_tbl[4] = '{1, 1, 0, 0, 1};
    rise_tbl[5] = '{1, 1, 1, 1, 0};
    rise_tbl[6] = '{1, 1, 0, 1, 0};
    rise_tbl[7] = '{1, 1, 0, 1, 0};

    model_reset();
    // Reset release, then idle low.
    step(0, 1, 1);
    step(0, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    check("idle_no_pulse", (pulses0 != 0), 1'b0);

    // Table-driven clean rise.
    for (int i = 0; i < 8; i++) begin
      step(rise_tbl[i].raw, rise_tbl[i].en, 0);
      check("rise_in_bit", ib0, rise_tbl[i].exp_in_bit);
      check("rise_level", lv0, rise_tbl[i].exp_level);
      check("rise_busy", bz0, rise_tbl[i].exp_busy);
    end

    // Glitch: settle low, three high cycles, back low.
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    pulses0 = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    check("glitch_no_pulse", (pulses0 != 0), 1'b0);
    check("glitch_level", lv0, 1'b0);
    check("glitch_busy", bz0, 1'b0);

    // Bounce then settle high: exactly one pulse, accumulator reads 1.
    pulses0 = 0;
    for (int i = 0; i < 9; i++) step(bounce[i][0], 1, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    acc = 4'(pulses0);
    check("bounce_acc_is_1", (acc == 4'd1), 1'b1);
    check("bounce_level", lv0, 1'b1);

    // Acceptance with enable low: no pulse, level still rises.
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    pulses0 = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("disabled_no_pulse", (pulses0 != 0), 1'b0);
    check("disabled_level", lv0, 1'b1);

    // Reset while pending high; asynchronous clear checked mid-cycle.
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    check("pend_busy_before_rst", bz0, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_busy", bz0, 1'b0);
    check("async_rst_level", lv0, 1'b0);
    compare_all();
    step(1, 1, 1);
    pulse_edge = 0;
    pulses0 = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1, 1, 0);
      if (ib0 && pulse_edge == 0) pulse_edge = e;
    end
    check("rst_repulse_edge6", (pulse_edge == 6), 1'b1);
    check("rst_repulse_once", (pulses0 == 1), 1'b1);

    // Full 0->1->0 cycle: two pulses with both-edge build, else one.
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    pulses0 = 0;
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    check("full_cycle_pulses", (pulses0 == (BOTH ? 2 : 1)), 1'b1);

    // Randomised runs against the model.
    raw_r = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic r;
      if ($urandom_range(0, 4) == 0) raw_r = ~raw_r;
      r = ($urandom_range(0, 299) == 0);
      step(raw_r, ($urandom_range(0, 3) != 0), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Consecutive in_bit highs must never occur.
  logic ib0_d = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ib0 && ib0_d) begin
      errors++;
      $display("FAIL double_pulse got=11 expected=not-consecutive at %0t", $time);
    end
    ib0_d = ib0;
  end

endmodule
